// File: rtl/e3_pkg.sv
// Shared constants, state type and helpers for the Excess-3 product-to-digits stage.
package e3_pkg;

    localparam int unsigned E3_OFFSET = 3;
    localparam logic [3:0]  E3_ZERO   = 4'b0011;
    localparam int unsigned MAX_PROD  = 81;
    // hundreds, tens and units nibbles of the double-dabble accumulator
    localparam int unsigned BCD_W     = 12;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_e;

    // Plain BCD nibble to Excess-3 nibble.
    function automatic logic [3:0] bin_to_e3(input logic [3:0] nibble);
        return nibble + 4'(E3_OFFSET);
    endfunction

endpackage

// File: rtl/e3_prod_to_digits_if.sv
// Handshake bundle between the multiplier, the digit converter and the consumer.
interface e3_prod_to_digits_if #(
    parameter int unsigned IN_W = 8
);

    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] in_prod;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_tens;
    logic [3:0]      out_units;
    logic            out_err;

    // Producer/consumer side
    modport master (
        output in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_tens, out_units, out_err
    );

    // Converter side
    modport slave (
        input  in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_tens, out_units, out_err
    );

endinterface

// File: rtl/e3_dd_step.sv
// One combinational double-dabble iteration: correct each BCD nibble, then shift left.
module e3_dd_step
    import e3_pkg::*;
#(
    parameter int unsigned IN_W = 8
) (
    input  logic [BCD_W+IN_W-1:0] vec_in,
    output logic [BCD_W+IN_W-1:0] vec_out
);

    logic [BCD_W-1:0] bcd_adj;

    // Add 3 to every nibble >= 5 (in parallel), then shift {bcd, bin} left by one
    always_comb begin
        bcd_adj = vec_in[BCD_W+IN_W-1:IN_W];
        for (int i = 0; i < int'(BCD_W / 4); i++) begin
            if (bcd_adj[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
            end
        end
        vec_out = {bcd_adj, vec_in[IN_W-1:0]} << 1;
    end

endmodule

// File: rtl/e3_prod_to_digits.sv
// Converts an Excess-3 coded product into Excess-3 tens/units digits with a
// sequential double-dabble (one bit per cycle), behind valid/ready handshakes.
module e3_prod_to_digits #(
    parameter int unsigned IN_W     = 8,
    parameter int unsigned MAX_PROD = e3_pkg::MAX_PROD
) (
    input logic               clk,
    input logic               rst_n,
    e3_prod_to_digits_if.slave bus
);

    import e3_pkg::*;

    localparam int unsigned CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [IN_W-1:0]         bin_q;
    logic [BCD_W-1:0]        bcd_q;
    logic                    err_r;

    logic                    out_valid_q;
    logic                    out_err_q;
    logic [3:0]              out_tens_q;
    logic [3:0]              out_units_q;

    logic [BCD_W+IN_W-1:0]   step_out;
    logic [BCD_W-1:0]        bcd_next;
    logic [IN_W-1:0]         bin_next;
    logic                    accept;
    logic                    last_iter;
    logic                    out_hs;

    e3_dd_step #(
        .IN_W (IN_W)
    ) u_step (
        .vec_in  ({bcd_q, bin_q}),
        .vec_out (step_out)
    );

    assign {bcd_next, bin_next} = step_out;

    assign accept    = (state_q == IDLE) && bus.in_valid;
    assign last_iter = (state_q == CONV) && (cnt_q == CNT_W'(IN_W - 1));
    assign out_hs    = (state_q == DONE) && bus.out_ready;

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_err   = out_err_q;
    assign bus.out_tens  = out_tens_q;
    assign bus.out_units = out_units_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid)  state_d = CONV;
            CONV:    if (last_iter)     state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Conversion datapath: load on accept, one double-dabble step per CONV cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            err_r <= 1'b0;
        end else if (accept) begin
            // Wraps for inputs below the offset; err_r flags those
            bin_q <= bus.in_prod - IN_W'(E3_OFFSET);
            bcd_q <= '0;
            cnt_q <= '0;
            err_r <= (bus.in_prod < IN_W'(E3_OFFSET)) ||
                     (bus.in_prod > IN_W'(MAX_PROD + E3_OFFSET));
        end else if (state_q == CONV) begin
            bin_q <= bin_next;
            bcd_q <= bcd_next;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Output registers: loaded from the final step, held until the handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_tens_q  <= E3_ZERO;
            out_units_q <= E3_ZERO;
        end else if (last_iter) begin
            out_valid_q <= 1'b1;
            out_err_q   <= err_r;
            out_tens_q  <= err_r ? E3_ZERO : bin_to_e3(bcd_next[7:4]);
            out_units_q <= err_r ? E3_ZERO : bin_to_e3(bcd_next[3:0]);
        end else if (out_hs) begin
            // Digits are kept; only valid and error drop
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_e3_prod_to_digits.sv
// Scoreboard bench for e3_prod_to_digits: accepts are turned into expected
// results by a decimal reference model; a monitor compares every output.
module tb_e3_prod_to_digits;

    localparam int LAT = 8;

    typedef struct {
        logic [7:0] prod;
        logic [3:0] tens;
        logic [3:0] units;
        logic       err;
        int         acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    int errors = 0;
    int checks = 0;
    int n_acc = 0;
    int n_hs = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    e3_prod_to_digits_if #(.IN_W(8)) bus ();

    e3_prod_to_digits #(
        .IN_W     (8),
        .MAX_PROD (81)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Decimal reference: product = code - 3, digits by division, +3 each
    function automatic exp_t ref_model(input logic [7:0] p, input int acc);
        exp_t e;
        int   v;
        v = int'(p) - 3;
        e.prod = p;
        e.acc_cyc = acc;
        if (v < 0 || v > 81) begin
            e.err = 1'b1;
            e.tens = 4'd3;
            e.units = 4'd3;
        end else begin
            e.err = 1'b0;
            e.tens = 4'(v / 10 + 3);
            e.units = 4'(v % 10 + 3);
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic run_monitor();
        logic       prev_valid;
        logic       prev_hs;
        logic [3:0] held_t;
        logic [3:0] held_u;
        logic       held_e;
        prev_valid = 1'b0;
        prev_hs = 1'b0;
        held_t = '0;
        held_u = '0;
        held_e = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                prev_valid = 1'b0;
                prev_hs = 1'b0;
                continue;
            end
            if (prev_hs) chk("in_ready_after_handshake", 32'(bus.in_ready), 1);
            prev_hs = 1'b0;
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(ref_model(bus.in_prod, cyc + 1));
                n_acc++;
            end
            if (bus.out_valid) begin
                if (!prev_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out_valid", 32'(bus.out_valid), 0);
                    end else begin
                        chk("latency", 32'(cyc - sb[0].acc_cyc), LAT);
                        chk("out_tens", 32'(bus.out_tens), 32'(sb[0].tens));
                        chk("out_units", 32'(bus.out_units), 32'(sb[0].units));
                        chk("out_err", 32'(bus.out_err), 32'(sb[0].err));
                    end
                end else begin
                    chk("hold_tens", 32'(bus.out_tens), 32'(held_t));
                    chk("hold_units", 32'(bus.out_units), 32'(held_u));
                    chk("hold_err", 32'(bus.out_err), 32'(held_e));
                end
                held_t = bus.out_tens;
                held_u = bus.out_units;
                held_e = bus.out_err;
                if (bus.out_ready) begin
                    if (sb.size() > 0) void'(sb.pop_front());
                    n_hs++;
                    prev_hs = 1'b1;
                end
            end
            prev_valid = bus.out_valid && !bus.out_ready;
        end
    endtask

    // Present a product until it is accepted, then drop in_valid
    task automatic send(input logic [7:0] p);
        int base;
        int n;
        base = n_acc;
        n = 0;
        @(posedge clk); #1;
        bus.in_prod = p;
        bus.in_valid = 1'b1;
        do begin
            @(negedge clk); #1;
            n++;
        end while (n_acc == base && n < 200);
        if (n_acc == base) chk("accept_timeout", 32'(n_acc), 32'(base + 1));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while ((sb.size() != 0 || bus.out_valid) && n < 400);
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 0);
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!bus.out_valid && n < 50);
        if (!bus.out_valid) chk("out_valid_timeout", 32'(bus.out_valid), 1);
    endtask

    initial begin
        int   base_acc;
        int   base_hs;
        logic done;
        logic [7:0] p;

        bus.in_valid = 1'b0;
        bus.in_prod = '0;
        bus.out_ready = 1'b0;
        fork
            run_monitor();
        join_none

        // Reset and idle state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_tens", 32'(bus.out_tens), 32'h3);
        chk("rst_units", 32'(bus.out_units), 32'h3);
        chk("rst_err", 32'(bus.out_err), 0);

        // Basic conversion and boundaries, consumer always ready
        bus.out_ready = 1'b1;
        send(8'd66);
        wait_drain();
        send(8'd3);
        send(8'd84);
        send(8'd85);
        send(8'd2);
        send(8'd255);
        send(8'd0);
        wait_drain();

        // Backpressure with a competing product held on the input
        bus.out_ready = 1'b0;
        base_acc = n_acc;
        send(8'd66);
        bus.in_prod = 8'd12;
        bus.in_valid = 1'b1;
        wait_out_valid();
        repeat (5) begin
            @(negedge clk); #1;
            chk("busy_in_ready", 32'(bus.in_ready), 0);
            chk("busy_no_accept", 32'(n_acc), 32'(base_acc + 1));
            chk("busy_out_valid", 32'(bus.out_valid), 1);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk); #1;
                n++;
            end while (n_acc != base_acc + 2 && n < 50);
            chk("second_accept", 32'(n_acc), 32'(base_acc + 2));
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_drain();

        // Reset during conversion discards the pending result
        send(8'd66);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(bus.in_ready), 1);
        chk("abort_out_valid", 32'(bus.out_valid), 0);
        chk("abort_tens", 32'(bus.out_tens), 32'h3);
        chk("abort_units", 32'(bus.out_units), 32'h3);
        chk("abort_err", 32'(bus.out_err), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk); #1;
            chk("abort_no_valid", 32'(bus.out_valid), 0);
        end
        send(8'd30);
        wait_drain();

        // Random legal stream with random consumer backpressure
        base_acc = n_acc;
        base_hs = n_hs;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    p = 8'($urandom_range(0, 9) * $urandom_range(0, 9) + 3);
                    send(p);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_drain();
        chk("stream_accepts", 32'(n_acc - base_acc), 10);
        chk("stream_results", 32'(n_hs - base_hs), 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
